bomb_pool: RTL
==============

Name: bomb_pool

Overview:
- Multi-bomb successor to the single-bomb placement/countdown logic.
- Manages up to MAX_BOMBS simultaneously live bombs. Each bomb gets its own tick-driven countdown.
- All bomb-place and bomb-clear writes into the tile map RAM go through one shared write port.
- Sits between player control (place request, pixel position) and the map memory / explosion renderer.

Parameters:
- NUM_ROW, 11, map rows
- NUM_COL, 19, map columns
- TILE_PX, 64, tile edge in pixels, power of 2
- SPRITE_W, 32, player sprite width in pixels
- SPRITE_H, 64, player sprite height in pixels
- MAP_MEM_WIDTH, 2, map word width
- MAX_BOMBS, 4, number of bomb slots, 1..16
- BOMB_TIME_TICKS, 3, ticks from placement to expiry, >=2
- BOMB_CODE, 2'd3, map code written on placement
- FREE_CODE, 2'd0, map code written on expiry
- BLAST_RADIUS, 2, tiles affected along row/column; used only with the optional feature

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- tick  in  1  one-cycle countdown strobe
- player_x  in  11  player left pixel x
- player_y  in  10  player top pixel y
- place_bomb  in  1  placement request, sampled every cycle
- write_addr  out  ADDR_WIDTH=$clog2(NUM_ROW*NUM_COL)  map write address
- write_data  out  MAP_MEM_WIDTH  map write data
- write_en  out  1  map write strobe
- place_ack  out  1  request accepted pulse
- place_reject  out  1  request refused pulse
- explode_valid  out  1  bomb-expired pulse
- explode_addr  out  ADDR_WIDTH  tile of exploding bomb
- active_count  out  $clog2(MAX_BOMBS+1)  live slot count

Behaviour:
- Tile computation:
  - col = (player_x + SPRITE_W/2) >> log2(TILE_PX)
  - row = (player_y + SPRITE_H/2) >> log2(TILE_PX)
  - addr = row*NUM_COL + col
  - Computed combinationally at full width, no truncation before the compare.
- Slot state: valid, row, col, countdown (width $clog2(BOMB_TIME_TICKS+1)), expired.
- Place evaluation on a cycle with place_bomb=1. The request is rejected if any of these holds:
  - row >= NUM_ROW or col >= NUM_COL
  - no free slot
  - a valid slot already holds the same row/col
  - pending_place is already set
- On reject: place_reject pulses the next cycle and no state changes.
- On accept, at that edge:
  - The lowest-index free slot is loaded with countdown=BOMB_TIME_TICKS.
  - pending_place is set and the address is latched.
  - place_ack pulses the next cycle.
- Countdown: on tick, every valid, non-expired slot decrements. Reaching 0 sets expired the same edge.
- A slot loaded in the same cycle as a tick does not decrement on that tick.
- Write arbiter: at most one map write per cycle; all outputs are registered.
  - Priority 1: the lowest-index expired slot. Drives write_en=1, write_data=FREE_CODE, write_addr=slot addr, explode_valid=1, explode_addr=slot addr. The slot's valid and expired bits are cleared at that edge.
  - Priority 2: pending_place. Drives write_en=1, write_data=BOMB_CODE. pending_place is cleared.
  - Otherwise write_en=0; write_addr/data hold their previous values.
- Latency:
  - Uncontested accept: write_en with BOMB_CODE appears 1 cycle after place_bomb, in the same cycle as place_ack.
  - Uncontested expiry: FREE write appears 1 cycle after the tick that zeroes the counter.
- Simultaneous expiries are serialised one per cycle in ascending slot order; none are lost.
- A freed slot is reusable from the edge at which its FREE write issues.
- active_count = popcount(valid), registered.
- Reset: all slots invalid, pending_place=0, and all outputs 0, including write_addr, write_data and explode_addr. Reset mid-countdown discards live bombs without issuing FREE writes.

Optional Feature:
- Macro: BOMB_POOL_CHAIN_REACT_EN.
- Defined: when a slot's FREE write issues, every other valid, non-expired slot in the same row with |col diff| <= BLAST_RADIUS, or in the same column with |row diff| <= BLAST_RADIUS, has expired set at that edge. It then explodes in subsequent cycles by normal priority.
- Undefined: bombs expire only by their own countdown; no blast-radius logic is synthesised.

Test Plan:
- Single bomb:
  - Stimulus: player_x=96, player_y=70, place_bomb for 1 cycle, ticks every 21 clocks.
  - Response: next cycle place_ack=1, write_en=1, write_addr=20, write_data=3, active_count=1.
  - Then 1 cycle after the 3rd tick: write_en=1, write_data=0, explode_valid=1, explode_addr=20, then active_count=0.
- Duplicate tile:
  - Stimulus: place at (96,70), then again at (100,80) before expiry.
  - Response: second request gives place_reject=1, no write, active_count stays 1.
- Capacity, with MAX_BOMBS=4:
  - Stimulus: place on tiles 20, 21, 22, 23, then a 5th request on 24.
  - Response: 5th gives place_reject; after slot 0 frees, a placement on 24 is accepted into slot 0.
- Simultaneous expiry and placement:
  - Stimulus: two bombs placed the same tick window, with a place request in the cycle after the expiring tick.
  - Response: FREE writes for slot 0 then slot 1 on consecutive cycles, BOMB write on the 3rd cycle, place_ack pulse retained.
- Out of range: player_x=1300 -> place_reject, no write.
- Reset mid-countdown:
  - Stimulus: assert rst 2 cycles after placement.
  - Response: all outputs 0, active_count=0, and no explode_valid afterwards.
- Chain reaction, with BOMB_POOL_CHAIN_REACT_EN defined:
  - Stimulus: bombs at tiles 20 and 22 placed 1 tick apart.
  - Response: tile 22's FREE write follows tile 20's by exactly 1 cycle.

Source files
------------

// File: rtl/bomb_pool.sv
// bomb_pool: multi-slot bomb placement, tick countdown and shared map write arbiter
// Ports: clk/rst (sync, active-high); tick countdown strobe; player_x/player_y sprite
// top-left pixel; place_bomb request; write_addr/write_data/write_en map write port;
// place_ack/place_reject request outcome pulses; explode_valid/explode_addr expiry pulse;
// active_count live slot count. All outputs are registered.
// Optional macro BOMB_POOL_CHAIN_REACT_EN: a freed bomb expires neighbours within BLAST_RADIUS.
module bomb_pool #(
    parameter int NUM_ROW = 11,
    parameter int NUM_COL = 19,
    parameter int TILE_PX = 64,
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 64,
    parameter int MAP_MEM_WIDTH = 2,
    parameter int MAX_BOMBS = 4,
    parameter int BOMB_TIME_TICKS = 3,
    parameter logic [MAP_MEM_WIDTH-1:0] BOMB_CODE = 2'd3,
    parameter logic [MAP_MEM_WIDTH-1:0] FREE_CODE = 2'd0,
    parameter int BLAST_RADIUS = 2,
    localparam int ADDR_WIDTH = $clog2(NUM_ROW*NUM_COL),
    localparam int AC_W = $clog2(MAX_BOMBS+1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic [10:0]              player_x,
    input  logic [9:0]               player_y,
    input  logic                     place_bomb,
    output logic [ADDR_WIDTH-1:0]    write_addr,
    output logic [MAP_MEM_WIDTH-1:0] write_data,
    output logic                     write_en,
    output logic                     place_ack,
    output logic                     place_reject,
    output logic                     explode_valid,
    output logic [ADDR_WIDTH-1:0]    explode_addr,
    output logic [AC_W-1:0]          active_count
);
    localparam int SHIFT = $clog2(TILE_PX);
    localparam int RW = $clog2(NUM_ROW);
    localparam int CW = $clog2(NUM_COL);
    localparam int CNT_W = $clog2(BOMB_TIME_TICKS+1);
    localparam int IW = MAX_BOMBS > 1 ? $clog2(MAX_BOMBS) : 1;

    logic [MAX_BOMBS-1:0] valid, expired, valid_n, expired_n, clr, free;
    logic [RW-1:0] s_row [MAX_BOMBS], row_n [MAX_BOMBS];
    logic [CW-1:0] s_col [MAX_BOMBS], col_n [MAX_BOMBS];
    logic [CNT_W-1:0] s_cnt [MAX_BOMBS], cnt_n [MAX_BOMBS];
    logic pending, in_range, has_exp, has_free, dup, accept;
    logic [IW-1:0] exp_idx, free_idx;
    logic [ADDR_WIDTH-1:0] pend_addr, place_addr, exp_addr;
    logic [RW-1:0] place_row;
    logic [CW-1:0] place_col;
    logic [AC_W-1:0] count_n;
    logic [11:0] col_full;
    logic [10:0] row_full;

    function automatic logic [ADDR_WIDTH-1:0] tile_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return ADDR_WIDTH'(32'(r) * NUM_COL + 32'(c));
    endfunction

`ifdef BOMB_POOL_CHAIN_REACT_EN
    function automatic logic in_blast(input logic [RW-1:0] ra, input logic [CW-1:0] ca,
                                      input logic [RW-1:0] rb, input logic [CW-1:0] cb);
        return (ra == rb && 32'(ca > cb ? ca - cb : cb - ca) <= BLAST_RADIUS) ||
               (ca == cb && 32'(ra > rb ? ra - rb : rb - ra) <= BLAST_RADIUS);
    endfunction
`endif

    // Sprite centre in pixels, kept wide so off-map positions are not wrapped back onto the map
    assign col_full = ({1'b0, player_x} + 12'(SPRITE_W/2)) >> SHIFT;
    assign row_full = ({1'b0, player_y} + 11'(SPRITE_H/2)) >> SHIFT;

    always_comb begin
        in_range = 32'(row_full) < NUM_ROW && 32'(col_full) < NUM_COL;
        place_row = RW'(row_full);
        place_col = CW'(col_full);
        place_addr = tile_addr(place_row, place_col);
        has_exp = 1'b0;
        exp_idx = '0;
        for (int i = MAX_BOMBS-1; i >= 0; i--)
            if (expired[i]) begin
                has_exp = 1'b1;
                exp_idx = IW'(i);
            end
        clr = '0;
        if (has_exp) clr[exp_idx] = 1'b1;
        // A slot being freed this edge is immediately available for a new bomb
        free = ~valid | clr;
        has_free = 1'b0;
        free_idx = '0;
        for (int i = MAX_BOMBS-1; i >= 0; i--)
            if (free[i]) begin
                has_free = 1'b1;
                free_idx = IW'(i);
            end
        dup = 1'b0;
        for (int i = 0; i < MAX_BOMBS; i++)
            if (valid[i] && !clr[i] && s_row[i] == place_row && s_col[i] == place_col) dup = 1'b1;
        accept = place_bomb && in_range && has_free && !dup && !pending;
        exp_addr = tile_addr(s_row[exp_idx], s_col[exp_idx]);
        valid_n = valid;
        expired_n = expired;
        cnt_n = s_cnt;
        row_n = s_row;
        col_n = s_col;
        for (int i = 0; i < MAX_BOMBS; i++)
            if (tick && valid[i] && !expired[i]) begin
                cnt_n[i] = s_cnt[i] - 1'b1;
                expired_n[i] = s_cnt[i] == CNT_W'(1);
            end
`ifdef BOMB_POOL_CHAIN_REACT_EN
        for (int i = 0; i < MAX_BOMBS; i++)
            if (has_exp && IW'(i) != exp_idx && valid[i] && !expired[i] &&
                in_blast(s_row[i], s_col[i], s_row[exp_idx], s_col[exp_idx]))
                expired_n[i] = 1'b1;
`endif
        // Loading wins over clearing and over the tick decrement
        for (int i = 0; i < MAX_BOMBS; i++) begin
            if (clr[i]) begin
                valid_n[i] = 1'b0;
                expired_n[i] = 1'b0;
            end
            if (accept && IW'(i) == free_idx) begin
                valid_n[i] = 1'b1;
                expired_n[i] = 1'b0;
                cnt_n[i] = CNT_W'(BOMB_TIME_TICKS);
                row_n[i] = place_row;
                col_n[i] = place_col;
            end
        end
        count_n = '0;
        for (int i = 0; i < MAX_BOMBS; i++) count_n = count_n + AC_W'(valid_n[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            expired <= '0;
            s_row <= '{default: '0};
            s_col <= '{default: '0};
            s_cnt <= '{default: '0};
            pending <= 1'b0;
            pend_addr <= '0;
            write_addr <= '0;
            write_data <= '0;
            write_en <= 1'b0;
            place_ack <= 1'b0;
            place_reject <= 1'b0;
            explode_valid <= 1'b0;
            explode_addr <= '0;
            active_count <= '0;
        end else begin
            valid <= valid_n;
            expired <= expired_n;
            s_row <= row_n;
            s_col <= col_n;
            s_cnt <= cnt_n;
            place_ack <= accept;
            place_reject <= place_bomb && !accept;
            active_count <= count_n;
            write_en <= has_exp || pending || accept;
            explode_valid <= has_exp;
            // A new placement is written at once unless a FREE write takes the port
            pending <= (pending || accept) && has_exp;
            if (accept) pend_addr <= place_addr;
            if (has_exp) begin
                write_addr <= exp_addr;
                write_data <= FREE_CODE;
                explode_addr <= exp_addr;
            end else if (pending || accept) begin
                write_addr <= pending ? pend_addr : place_addr;
                write_data <= BOMB_CODE;
            end
        end
    end
endmodule
